cmd_frame_decode: RTL and testbench

- Parametrised UART command-frame decoder between the UART receiver and the SDRAM write FIFO / read controller.
- A write-command byte opens a frame; the next PAYLOAD_LEN bytes are pushed into the write FIFO, then a write trigger fires.
- A read-command byte fires a read trigger.
- Adds configurable payload length and command codes, inter-byte timeout, FIFO-full protection and error strobes.

---
 rtl/cmd_frame_decode_if.sv | 30 +++
 rtl/cmd_frame_decode.sv | 187 ++++++++++++++++++
 tb/tb_cmd_frame_decode.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_frame_decode_if.sv
// Bus bundle between the UART receiver, cmd_frame_decode and the SDRAM write FIFO / read controller.
// The decoder takes the master side; the surrounding logic (or a testbench) takes the slave side.
interface cmd_frame_decode_if #(
    parameter int DATA_W = 8
);
    logic              rx_done;
    logic [DATA_W-1:0] uart_data;
    logic              wfifo_full;
    logic              wfifo_wr_en;
    logic [DATA_W-1:0] wfifo_data;
    logic              wr_trig;
    logic              rd_trig;
    logic              busy;
    logic              err_timeout;
    logic              err_ovf;
    logic              err_unknown;
    logic              err_chk;

    modport master (
        input  rx_done, uart_data, wfifo_full,
        output wfifo_wr_en, wfifo_data, wr_trig, rd_trig, busy,
               err_timeout, err_ovf, err_unknown, err_chk
    );

    modport slave (
        output rx_done, uart_data, wfifo_full,
        input  wfifo_wr_en, wfifo_data, wr_trig, rd_trig, busy,
               err_timeout, err_ovf, err_unknown, err_chk
    );
endinterface

// File: rtl/cmd_frame_decode.sv
// UART command-frame decoder: write frames go into the SDRAM write FIFO, read commands pulse rd_trig.
// Define CMD_FRAME_CHECKSUM_EN to require a trailing mod-2^DATA_W checksum byte on every write frame.
module cmd_frame_decode #(
    parameter int                DATA_W      = 8,
    parameter int                PAYLOAD_LEN = 4,
    parameter logic [DATA_W-1:0] WR_CMD      = 8'h55,
    parameter logic [DATA_W-1:0] RD_CMD      = 8'hAA,
    parameter int                TIMEOUT_CYC = 50000
) (
    input logic                clk,
    input logic                rst,
    cmd_frame_decode_if.master bus
);
    localparam int              BC_W      = $clog2(PAYLOAD_LEN + 1);
    localparam int              TO_W      = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit              TO_EN     = (TIMEOUT_CYC > 0);
    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(PAYLOAD_LEN - 1);
    localparam logic [TO_W-1:0] TO_LAST   = (TIMEOUT_CYC > 0) ? TO_W'(TIMEOUT_CYC - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        WR_PAYLOAD,
`ifdef CMD_FRAME_CHECKSUM_EN
        CHK,
`endif
        FINISH
    } state_t;

    state_t            state, state_nxt;
    logic [BC_W-1:0]   byte_cnt, byte_cnt_nxt;
    logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
    logic              wr_en_q, wr_en_nxt;
    logic [DATA_W-1:0] data_q, data_nxt;
    logic              wr_trig_q, wr_trig_nxt;
    logic              rd_trig_q, rd_trig_nxt;
    logic              busy_q, busy_nxt;
    logic              err_timeout_q, err_timeout_nxt;
    logic              err_ovf_q, err_ovf_nxt;
    logic              err_unknown_q, err_unknown_nxt;
    logic              timeout_hit;
`ifdef CMD_FRAME_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_nxt;
    logic              err_chk_q, err_chk_nxt;
`endif

    // An rx_done in the expiry cycle takes priority, so the hit is qualified by its absence.
    assign timeout_hit = TO_EN && !bus.rx_done && (to_cnt == TO_LAST);

    always_comb begin
        state_nxt       = state;
        byte_cnt_nxt    = byte_cnt;
        to_cnt_nxt      = '0;
        wr_en_nxt       = 1'b0;
        data_nxt        = data_q;
        wr_trig_nxt     = 1'b0;
        rd_trig_nxt     = 1'b0;
        err_timeout_nxt = 1'b0;
        err_ovf_nxt     = 1'b0;
        err_unknown_nxt = 1'b0;
`ifdef CMD_FRAME_CHECKSUM_EN
        sum_nxt         = sum_q;
        err_chk_nxt     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (bus.rx_done) begin
                    if (bus.uart_data == WR_CMD) begin
                        state_nxt    = WR_PAYLOAD;
                        byte_cnt_nxt = '0;
`ifdef CMD_FRAME_CHECKSUM_EN
                        sum_nxt      = '0;
`endif
                    end else if (bus.uart_data == RD_CMD) begin
                        rd_trig_nxt = 1'b1;
                    end else begin
                        err_unknown_nxt = 1'b1;
                    end
                end
            end
            WR_PAYLOAD: begin
                if (TO_EN && !bus.rx_done) begin
                    to_cnt_nxt = to_cnt + TO_W'(1);
                end
                if (bus.rx_done) begin
                    if (bus.wfifo_full) begin
                        err_ovf_nxt = 1'b1;
                        state_nxt   = IDLE;
                    end else begin
                        wr_en_nxt    = 1'b1;
                        data_nxt     = bus.uart_data;
                        byte_cnt_nxt = byte_cnt + BC_W'(1);
`ifdef CMD_FRAME_CHECKSUM_EN
                        sum_nxt      = sum_q + bus.uart_data;
                        if (byte_cnt == LAST_BYTE) begin
                            state_nxt = CHK;
                        end
`else
                        if (byte_cnt == LAST_BYTE) begin
                            state_nxt = FINISH;
                        end
`endif
                    end
                end else if (timeout_hit) begin
                    err_timeout_nxt = 1'b1;
                    state_nxt       = IDLE;
                end
            end
`ifdef CMD_FRAME_CHECKSUM_EN
            // The checksum byte never reaches the FIFO, so FIFO-full is irrelevant here.
            CHK: begin
                if (TO_EN && !bus.rx_done) begin
                    to_cnt_nxt = to_cnt + TO_W'(1);
                end
                if (bus.rx_done) begin
                    state_nxt = IDLE;
                    if (bus.uart_data == sum_q) begin
                        wr_trig_nxt = 1'b1;
                    end else begin
                        err_chk_nxt = 1'b1;
                    end
                end else if (timeout_hit) begin
                    err_timeout_nxt = 1'b1;
                    state_nxt       = IDLE;
                end
            end
`endif
            FINISH: begin
                wr_trig_nxt = 1'b1;
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            byte_cnt      <= '0;
            to_cnt        <= '0;
            wr_en_q       <= 1'b0;
            data_q        <= '0;
            wr_trig_q     <= 1'b0;
            rd_trig_q     <= 1'b0;
            busy_q        <= 1'b0;
            err_timeout_q <= 1'b0;
            err_ovf_q     <= 1'b0;
            err_unknown_q <= 1'b0;
`ifdef CMD_FRAME_CHECKSUM_EN
            sum_q         <= '0;
            err_chk_q     <= 1'b0;
`endif
        end else begin
            state         <= state_nxt;
            byte_cnt      <= byte_cnt_nxt;
            to_cnt        <= to_cnt_nxt;
            wr_en_q       <= wr_en_nxt;
            data_q        <= data_nxt;
            wr_trig_q     <= wr_trig_nxt;
            rd_trig_q     <= rd_trig_nxt;
            busy_q        <= busy_nxt;
            err_timeout_q <= err_timeout_nxt;
            err_ovf_q     <= err_ovf_nxt;
            err_unknown_q <= err_unknown_nxt;
`ifdef CMD_FRAME_CHECKSUM_EN
            sum_q         <= sum_nxt;
            err_chk_q     <= err_chk_nxt;
`endif
        end
    end

    assign bus.wfifo_wr_en = wr_en_q;
    assign bus.wfifo_data  = data_q;
    assign bus.wr_trig     = wr_trig_q;
    assign bus.rd_trig     = rd_trig_q;
    assign bus.busy        = busy_q;
    assign bus.err_timeout = err_timeout_q;
    assign bus.err_ovf     = err_ovf_q;
    assign bus.err_unknown = err_unknown_q;
`ifdef CMD_FRAME_CHECKSUM_EN
    assign bus.err_chk     = err_chk_q;
`else
    assign bus.err_chk     = 1'b0;
`endif
endmodule

// File: tb/tb_cmd_frame_decode.sv
// Bench for cmd_frame_decode: directed frames followed by random byte traffic, both checked every cycle
// against an event schedule built from the frame rules (busy windows, pulses and timeouts per received byte).
`timescale 1ns/1ps
module tb_cmd_frame_decode;
    localparam int         DATA_W      = 8;
    localparam int         PAYLOAD_LEN = 4;
    localparam logic [7:0] WR_CMD      = 8'h55;
    localparam logic [7:0] RD_CMD      = 8'hAA;
    localparam int         TIMEOUT_CYC = 16;
    localparam int         MAXC        = 8192;

    localparam int B_WR   = 7;
    localparam int B_TRIG = 6;
    localparam int B_RD   = 5;
    localparam int B_BUSY = 4;
    localparam int B_TO   = 3;
    localparam int B_OVF  = 2;
    localparam int B_UNK  = 1;
    localparam int B_CHK  = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cmd_frame_decode_if #(.DATA_W(DATA_W)) bus ();

    cmd_frame_decode #(
        .DATA_W     (DATA_W),
        .PAYLOAD_LEN(PAYLOAD_LEN),
        .WR_CMD     (WR_CMD),
        .RD_CMD     (RD_CMD),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [7:0] exp_flags [MAXC];
    logic [7:0] exp_data  [MAXC];
    int         cyc;
    int         n_checks;
    int         n_fail;
    string      phase;

    bit         frame_open;
    bit         in_chk;
    int         last_cyc;
    int         pay_cnt;
    logic [7:0] pay_sum;

    function automatic void setFlag(int c, int pos);
        if (c < MAXC) exp_flags[c][pos] = 1'b1;
    endfunction

    function automatic void clearFrom(int c);
        for (int j = c; j < c + TIMEOUT_CYC + 4 && j < MAXC; j++) begin
            exp_flags[j][B_BUSY] = 1'b0;
            exp_flags[j][B_TO]   = 1'b0;
        end
    endfunction

    // An open frame is busy until the next byte, or until the timeout pulse TIMEOUT_CYC+1 cycles later.
    function automatic void armFrame(int c);
        clearFrom(c + 1);
        for (int j = c + 1; j <= c + TIMEOUT_CYC && j < MAXC; j++) exp_flags[j][B_BUSY] = 1'b1;
        setFlag(c + TIMEOUT_CYC + 1, B_TO);
    endfunction

    function automatic void modelByte(int c, logic [7:0] b, bit full);
        bit open_now;
        open_now = frame_open && (c <= last_cyc + TIMEOUT_CYC);
        if (!open_now) begin
            frame_open = 1'b0;
            if (b == WR_CMD) begin
                frame_open = 1'b1;
                in_chk     = 1'b0;
                pay_cnt    = 0;
                pay_sum    = 8'h00;
                last_cyc   = c;
                armFrame(c);
            end else if (b == RD_CMD) begin
                setFlag(c + 1, B_RD);
            end else begin
                setFlag(c + 1, B_UNK);
            end
        end else begin
            last_cyc = c;
            if (in_chk) begin
                clearFrom(c + 1);
                frame_open = 1'b0;
                setFlag(c + 1, (b == pay_sum) ? B_TRIG : B_CHK);
            end else if (full) begin
                clearFrom(c + 1);
                frame_open = 1'b0;
                setFlag(c + 1, B_OVF);
            end else begin
                setFlag(c + 1, B_WR);
                if (c + 1 < MAXC) exp_data[c + 1] = b;
                pay_cnt++;
                pay_sum = pay_sum + b;
                if (pay_cnt == PAYLOAD_LEN) begin
`ifdef CMD_FRAME_CHECKSUM_EN
                    in_chk = 1'b1;
                    armFrame(c);
`else
                    clearFrom(c + 1);
                    setFlag(c + 1, B_BUSY);
                    setFlag(c + 2, B_TRIG);
                    frame_open = 1'b0;
`endif
                end else begin
                    armFrame(c);
                end
            end
        end
    endfunction

    task automatic checkOutput();
        logic [7:0] obs;
        logic [7:0] exp;
        obs = {bus.wfifo_wr_en, bus.wr_trig, bus.rd_trig, bus.busy,
               bus.err_timeout, bus.err_ovf, bus.err_unknown, bus.err_chk};
        exp = (cyc < MAXC) ? exp_flags[cyc] : 8'h00;
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s flags cyc=%0d observed=%b expected=%b (wr,trig,rd,busy,to,ovf,unk,chk)",
                   phase, cyc, obs, exp);
        end
        if (exp[B_WR]) begin
            n_checks++;
            assert (bus.wfifo_data === exp_data[cyc]) else begin
                n_fail++;
                $error("[TB] FAIL %s wfifo_data cyc=%0d observed=%h expected=%h",
                       phase, cyc, bus.wfifo_data, exp_data[cyc]);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (cyc >= MAXC) begin
            $display("[TB] FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
            $fatal(1, "[TB] cycle budget exhausted");
        end
        checkOutput();
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit full, input int gap);
        bus.rx_done    = 1'b1;
        bus.uart_data  = b;
        bus.wfifo_full = full;
        modelByte(cyc, b, full);
        tick();
        bus.rx_done    = 1'b0;
        bus.wfifo_full = 1'b0;
        bus.uart_data  = 8'($urandom);
        repeat (gap - 1) tick();
    endtask

    task automatic applyReset(input int len);
        rst = 1'b1;
        for (int j = cyc + 1; j < cyc + TIMEOUT_CYC + 4 && j < MAXC; j++) exp_flags[j] = 8'h00;
        frame_open = 1'b0;
        in_chk     = 1'b0;
        repeat (len) tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        int         r;
        for (int j = 0; j < MAXC; j++) begin
            exp_flags[j] = 8'h00;
            exp_data[j]  = 8'h00;
        end
        cyc = 0; n_checks = 0; n_fail = 0;
        frame_open = 1'b0; in_chk = 1'b0; last_cyc = 0; pay_cnt = 0; pay_sum = 8'h00;
        bus.rx_done = 1'b0; bus.uart_data = 8'h00; bus.wfifo_full = 1'b0;
        rst = 1'b1;
        phase = "reset";
        repeat (2) @(negedge clk);
        applyReset(2);
        tick();

        $display("[TB] directed frame 55,01,02,03,04");
        phase = "frame";
        applyStimulus(WR_CMD, 1'b0, 10);
        applyStimulus(8'h01, 1'b0, 10);
        applyStimulus(8'h02, 1'b0, 10);
        applyStimulus(8'h03, 1'b0, 10);
        applyStimulus(8'h04, 1'b0, 10);
        phase = "rd_unknown";
        applyStimulus(RD_CMD, 1'b0, 10);
        applyStimulus(8'h37, 1'b0, 10);

        $display("[TB] timeout and recovery");
        phase = "timeout";
        applyStimulus(WR_CMD, 1'b0, 10);
        applyStimulus(8'h01, 1'b0, TIMEOUT_CYC + 8);
        phase = "after_timeout";
        applyStimulus(WR_CMD, 1'b0, 5);
        applyStimulus(8'hAA, 1'b0, 5);
        applyStimulus(8'hBB, 1'b0, 5);
        applyStimulus(8'hCC, 1'b0, 5);
        applyStimulus(8'hDD, 1'b0, 10);
        phase = "expiry_edge";
        applyStimulus(WR_CMD, 1'b0, TIMEOUT_CYC);
        applyStimulus(8'h11, 1'b0, TIMEOUT_CYC + 1);
        applyStimulus(8'h22, 1'b0, 10);

        $display("[TB] fifo full on third payload byte");
        phase = "ovf";
        applyStimulus(WR_CMD, 1'b0, 5);
        applyStimulus(8'h01, 1'b0, 5);
        applyStimulus(8'h02, 1'b0, 5);
        applyStimulus(8'h03, 1'b1, 5);
        applyStimulus(RD_CMD, 1'b0, 10);

        $display("[TB] reset mid-frame");
        phase = "rst_mid";
        applyStimulus(WR_CMD, 1'b0, 5);
        applyStimulus(8'h01, 1'b0, 3);
        applyReset(2);
        tick();
        applyStimulus(8'h02, 1'b0, 5);
        applyStimulus(8'h03, 1'b0, 5);
        applyStimulus(8'h04, 1'b0, 10);

`ifdef CMD_FRAME_CHECKSUM_EN
        $display("[TB] checksum frames");
        phase = "chk_ok";
        applyStimulus(WR_CMD, 1'b0, 5);
        applyStimulus(8'h01, 1'b0, 5);
        applyStimulus(8'h02, 1'b0, 5);
        applyStimulus(8'h03, 1'b0, 5);
        applyStimulus(8'h04, 1'b0, 5);
        applyStimulus(8'h0A, 1'b0, 10);
        phase = "chk_bad";
        applyStimulus(WR_CMD, 1'b0, 5);
        applyStimulus(8'h01, 1'b0, 5);
        applyStimulus(8'h02, 1'b0, 5);
        applyStimulus(8'h03, 1'b0, 5);
        applyStimulus(8'h04, 1'b0, 5);
        applyStimulus(8'h0B, 1'b0, 10);
`endif

        $display("[TB] random traffic");
        phase = "random";
        for (int n = 0; n < 200 && cyc < MAXC - 64; n++) begin
            r = $urandom_range(0, 9);
            if (r < 3)       b = WR_CMD;
            else if (r == 3) b = RD_CMD;
            else             b = 8'($urandom);
            applyStimulus(b, ($urandom_range(0, 19) == 0), $urandom_range(3, TIMEOUT_CYC + 6));
        end
        repeat (TIMEOUT_CYC + 5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
